// File: rtl/seg7_mux.sv
// seg7_mux -- time-multiplexed hex driver for a DIGITS-wide 7-segment display.
//
// Scans one digit at a time. Each digit stays lit for REFRESH_DIV clocks.
// New values go into a shadow register on `load`. The shadow is copied to
// the active register only when the scan wraps from the last digit back to
// digit 0. Because of this, a frame never shows a half-updated value.
//
// Parameters:
//   DIGITS       number of digits (>= 1)
//   REFRESH_DIV  clocks per digit (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        single-cycle strobe: capture value_in/dp_in into the shadow
//   value_in    nibble i (bits 4i+3:4i) drives digit i; digit 0 is the LSD
//   dp_in       decimal point per digit
//   blank       level input: forces every digit enable off while high
//   seg         segments a..g on seg[0]..seg[6], active-high, registered
//   dp          decimal point of the lit digit, active-high, registered
//   an          one-hot digit enable, active-high, registered
//   frame_tick  one-cycle pulse after the shadow->active transfer
//
// Build option:
//   SEG7_LZB_EN  leading-zero blanking. A digit i > 0 has its segments
//                forced off when it and every more-significant active
//                nibble are zero. Its dp still follows the active dp.
//                Digit 0 is never blanked.

module seg7_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic [4*DIGITS-1:0] active_val;
    logic [DIGITS-1:0]   active_dp;

    logic                digit_done;
    logic                frame_wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign digit_done = (cnt == CNT_LAST);
    assign frame_wrap = digit_done && (idx == IDX_LAST);

`ifdef SEG7_LZB_EN
    // lz[i] is set when nibble i and every nibble above it are zero.
    // lz[0] is left clear, so digit 0 always shows something.
    logic [DIGITS-1:0] lz;
    logic              zero_run;
    logic              cur_lz;

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (active_val[4*i +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
    end
`endif

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        an_next = '0;
`ifdef SEG7_LZB_EN
        cur_lz  = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            an_next[i] = (idx == IDX_W'(i));
            if (idx == IDX_W'(i)) begin
                cur_nib = active_val[4*i +: 4];
                cur_dp  = active_dp[i];
`ifdef SEG7_LZB_EN
                cur_lz  = lz[i];
`endif
            end
        end
`ifdef SEG7_LZB_EN
        seg_next = cur_lz ? 7'h00 : hex_to_seg(cur_nib);
`else
        seg_next = hex_to_seg(cur_nib);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (digit_done) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // On a wrap edge the active register takes the pre-edge shadow.
            // A load on that same edge lands in the shadow for the next frame.
            if (frame_wrap) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            frame_tick <= frame_wrap;

            if (load) begin
                shadow_val <= value_in;
                shadow_dp  <= dp_in;
            end

            // The output stage always reflects the idx and active state
            // from one cycle earlier.
            an  <= blank ? '0 : an_next;
            seg <= seg_next;
            dp  <= cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_mux.sv
module tb_seg7_mux;

    localparam int D = 4;
    localparam int R = 4;
    localparam int F = D * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    seg7_mux #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
        .dp_in(dp_in), .blank(blank), .seg(seg), .dp(dp), .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: edges counted since reset release, plus the
    // shadow and active contents.
    int          edge_n;
    logic [15:0] sh_v, ac_v;
    logic [3:0]  sh_dp, ac_dp;
    logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic model_reset();
        edge_n = 0;
        sh_v = '0; ac_v = '0; sh_dp = '0; ac_dp = '0;
    endtask

    // One clock: drive inputs, take the edge, update the model, then check
    // outputs 1 time unit after the edge. Returns at the next falling edge.
    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] dv,
                         input logic bl, input string tag);
        int          dig;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [6:0]  es;
        logic [3:0]  ea;
        logic        ed, et;
        load = ld; value_in = v; dp_in = dv; blank = bl;
        @(posedge clk);
        edge_n++;
        dig   = ((edge_n - 1) / R) % D;
        upper = ac_v >> (4 * dig);
        nib   = upper[3:0];
        es    = lut[nib];
`ifdef SEG7_LZB_EN
        if (dig > 0 && upper == 16'h0) es = 7'h00;
`endif
        ed = ac_dp[dig];
        ea = bl ? 4'b0000 : 4'(1 << dig);
        et = (edge_n % F == 0);
        if (et) begin ac_v = sh_v; ac_dp = sh_dp; end
        if (ld) begin sh_v = v; sh_dp = dv; end
        #1;
        n_checks++;
        if (an !== ea) $display("FAIL %s an edge=%0d got=%b exp=%b", tag, edge_n, an, ea);
        else n_pass++;
        n_checks++;
        if (seg !== es) $display("FAIL %s seg edge=%0d got=%h exp=%h", tag, edge_n, seg, es);
        else n_pass++;
        n_checks++;
        if (dp !== ed) $display("FAIL %s dp edge=%0d got=%b exp=%b", tag, edge_n, dp, ed);
        else n_pass++;
        n_checks++;
        if (frame_tick !== et) $display("FAIL %s frame_tick edge=%0d got=%b exp=%b", tag, edge_n, frame_tick, et);
        else n_pass++;
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 1'b0, tag);
    endtask

    // Runs idle cycles until the next edge is the one at (edge_n+1) % F == phase.
    task automatic go_to_phase(input int phase, input string tag);
        for (int i = 0; i < F && ((edge_n + 1) % F) != phase; i++) cycle(1'b0, 16'h0, 4'h0, 1'b0, tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        n_checks++;
        if (an !== 4'b0 || seg !== 7'h0 || dp !== 1'b0 || frame_tick !== 1'b0)
            $display("FAIL %s outputs an=%b seg=%h dp=%b ft=%b exp all zero", tag, an, seg, dp, frame_tick);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_state");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle(2 * F + 4, "reset_scan");
    endtask

    task automatic test_double_buffer();
        go_to_phase(6, "dbuf_align");
        cycle(1'b1, 16'h1A2F, 4'h0, 1'b0, "dbuf_load");
        idle(2 * F, "dbuf_run");
    endtask

    task automatic test_load_on_wrap();
        go_to_phase(5, "wrap_align");
        cycle(1'b1, 16'h00FF, 4'h0, 1'b0, "wrap_first");
        go_to_phase(0, "wrap_align2");
        cycle(1'b1, 16'h0001, 4'h0, 1'b0, "wrap_edge_load");
        idle(2 * F + 2, "wrap_run");
    endtask

    task automatic test_back_to_back();
        go_to_phase(3, "b2b_align");
        cycle(1'b1, 16'h1234, 4'hF, 1'b0, "b2b_a");
        cycle(1'b1, 16'hCDEF, 4'h2, 1'b0, "b2b_b");
        idle(3, "b2b_gap");
        cycle(1'b1, 16'h9876, 4'h8, 1'b0, "b2b_c");
        idle(2 * F, "b2b_run");
    endtask

    task automatic test_blank();
        go_to_phase(7, "blank_align");
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0, 4'h0, 1'b1, "blank_high");
        idle(F + 3, "blank_resume");
    endtask

    task automatic test_decimal_points();
        go_to_phase(9, "dp_align");
        cycle(1'b1, 16'h4321, 4'b0101, 1'b0, "dp_load");
        idle(2 * F, "dp_run");
    endtask

    task automatic test_leading_zero();
        go_to_phase(2, "lzb_align");
        cycle(1'b1, 16'h0050, 4'h0, 1'b0, "lzb_0050");
        idle(2 * F, "lzb_run1");
        cycle(1'b1, 16'h0000, 4'b1000, 1'b0, "lzb_0000");
        idle(2 * F, "lzb_run2");
    endtask

    task automatic test_random();
        logic        ld, bl;
        logic [15:0] v;
        logic [3:0]  dv;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 9) == 0);
            v  = 16'($urandom);
            dv = 4'($urandom);
            cycle(ld, v, dv, bl, "random");
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 16'h8888, 4'hF, 1'b0, "arst_pending");
        go_to_phase(11, "arst_align");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle(2 * F + 2, "arst_after");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_double_buffer();
        test_load_on_wrap();
        test_back_to_back();
        test_blank();
        test_decimal_points();
        test_leading_zero();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
